// File: rtl/pipeline_ctrl_gen.sv
// Pipeline controller: prefix stall/bubble generation, exception/ertn flush,
// registered PC redirect under valid/ready, and a saturating stall-cycle counter.
module pipeline_ctrl_gen #(
  parameter int unsigned STAGES     = 6,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CSR_ADDR_W = 14,
  parameter logic [CSR_ADDR_W-1:0] CSR_ERA    = 14'h006,
  parameter logic [CSR_ADDR_W-1:0] CSR_EENTRY = 14'h00c,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [STAGES-1:0]     stall_req,
  input  logic                  is_exception,
  input  logic                  is_ertn,
  input  logic [ADDR_W-1:0]     eentry_va,
  input  logic [ADDR_W-1:0]     era_pc,
  input  logic                  wb_csr_we,
  input  logic [CSR_ADDR_W-1:0] wb_csr_waddr,
  input  logic [DATA_W-1:0]     wb_csr_wdata,
  input  logic                  redirect_ready,
  output logic [STAGES-1:0]     pause,
  output logic [STAGES-1:0]     bubble,
  output logic [STAGES-1:0]     flush,
  output logic                  redirect_valid,
  output logic [ADDR_W-1:0]     redirect_pc,
  output logic                  redirect_ertn,
  output logic [CNT_W-1:0]      stall_cycles
);

  typedef enum logic {IDLE, REDIRECT} state_t;
  state_t state;

  logic [STAGES-1:0] pause_raw;
  logic [STAGES-1:0] bubble_raw;
  logic [ADDR_W-1:0] era_cur;
  logic [ADDR_W-1:0] eentry_cur;
  logic [ADDR_W-1:0] target;
  logic              event_in;

  // Suffix OR from the oldest stage downwards: a stall holds all younger stages.
  always_comb begin
    pause_raw             = '0;
    pause_raw[STAGES-1]   = stall_req[STAGES-1];
    for (int unsigned k = 0; k < STAGES - 1; k++) begin
      pause_raw[STAGES-2-k] = pause_raw[STAGES-1-k] | stall_req[STAGES-2-k];
    end
  end

  always_comb begin
    bubble_raw = '0;
    for (int unsigned i = 0; i < STAGES - 1; i++) begin
      bubble_raw[i+1] = pause_raw[i] & ~pause_raw[i+1];
    end
  end

  assign era_cur    = (wb_csr_we && wb_csr_waddr == CSR_ERA)    ? wb_csr_wdata[ADDR_W-1:0] : era_pc;
  assign eentry_cur = (wb_csr_we && wb_csr_waddr == CSR_EENTRY) ? wb_csr_wdata[ADDR_W-1:0] : eentry_va;
  assign target     = is_ertn ? era_cur : eentry_cur;
  assign event_in   = is_exception | is_ertn;

  always_comb begin
    pause  = '0;
    bubble = '0;
    flush  = '0;
    if (rst_n) begin
      if (state == REDIRECT || event_in) begin
        flush = '1;
      end else begin
        pause  = pause_raw;
        bubble = bubble_raw;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      redirect_ertn  <= 1'b0;
      stall_cycles   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (event_in) begin
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
            redirect_ertn  <= is_ertn;
          end else if (|pause_raw && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 1'b1;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl_gen.sv
// Directed bench for pipeline_ctrl_gen: stall vectors, redirect handshake,
// CSR bypass, reset abort and counter saturation (second instance, CNT_W=4).
module tb_pipeline_ctrl_gen;

  logic        clk;
  logic        rst_n;
  logic [5:0]  stall_req;
  logic        is_exception;
  logic        is_ertn;
  logic [31:0] eentry_va;
  logic [31:0] era_pc;
  logic        wb_csr_we;
  logic [13:0] wb_csr_waddr;
  logic [31:0] wb_csr_wdata;
  logic        redirect_ready;
  logic [5:0]  pause, bubble, flush;
  logic        redirect_valid, redirect_ertn;
  logic [31:0] redirect_pc;
  logic [31:0] stall_cycles;
  logic [5:0]  pause4, bubble4, flush4;
  logic        redirect_valid4, redirect_ertn4;
  logic [31:0] redirect_pc4;
  logic [3:0]  stall_cycles4;

  int n_checks = 0;
  int n_pass   = 0;

  pipeline_ctrl_gen u_dut (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req),
    .is_exception(is_exception), .is_ertn(is_ertn),
    .eentry_va(eentry_va), .era_pc(era_pc),
    .wb_csr_we(wb_csr_we), .wb_csr_waddr(wb_csr_waddr), .wb_csr_wdata(wb_csr_wdata),
    .redirect_ready(redirect_ready),
    .pause(pause), .bubble(bubble), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ertn(redirect_ertn), .stall_cycles(stall_cycles)
  );

  pipeline_ctrl_gen #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req),
    .is_exception(is_exception), .is_ertn(is_ertn),
    .eentry_va(eentry_va), .era_pc(era_pc),
    .wb_csr_we(wb_csr_we), .wb_csr_waddr(wb_csr_waddr), .wb_csr_wdata(wb_csr_wdata),
    .redirect_ready(redirect_ready),
    .pause(pause4), .bubble(bubble4), .flush(flush4),
    .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
    .redirect_ertn(redirect_ertn4), .stall_cycles(stall_cycles4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall_req = 6'h3f; is_exception = 1'b0; is_ertn = 1'b0;
    eentry_va = '0; era_pc = '0; wb_csr_we = 1'b0; wb_csr_waddr = '0;
    wb_csr_wdata = '0; redirect_ready = 1'b1;
    #3;
    check("rst_pause", pause, 0);
    check("rst_bubble", bubble, 0);
    check("rst_flush", flush, 0);
    check("rst_valid", redirect_valid, 0);
    check("rst_pc", redirect_pc, 0);
    check("rst_cnt", stall_cycles, 0);
    tick();
    rst_n = 1'b1; stall_req = 6'b000000;

    // Combinational stall patterns
    stall_req = 6'b100001; #1;
    check("pat1_pause", pause, 6'h3f);
    check("pat1_bubble", bubble, 6'h00);
    stall_req = 6'b000010; #1;
    check("pat2_pause", pause, 6'b000011);
    check("pat2_bubble", bubble, 6'b000100);
    stall_req = 6'b001000; #1;
    check("pat3_pause", pause, 6'b001111);
    check("pat3_bubble", bubble, 6'b010000);
    check("pat3_flush", flush, 0);
    tick(); tick(); tick();
    check("cnt_3", stall_cycles, 3);
    stall_req = '0;
    tick();
    check("cnt_hold", stall_cycles, 3);

    // Exception, ready high: two-cycle round trip
    stall_req = 6'b001000; eentry_va = 32'h1c00_8000; is_exception = 1'b1; #1;
    check("exc_flush_t", flush, 6'h3f);
    check("exc_pause_t", pause, 0);
    check("exc_bubble_t", bubble, 0);
    tick();
    is_exception = 1'b0;
    check("exc_valid_t1", redirect_valid, 1);
    check("exc_pc_t1", redirect_pc, 32'h1c00_8000);
    check("exc_ertn_t1", redirect_ertn, 0);
    check("exc_flush_t1", flush, 6'h3f);
    check("exc_pause_t1", pause, 0);
    tick();
    check("exc_valid_t2", redirect_valid, 0);
    check("exc_flush_t2", flush, 0);
    check("exc_pause_t2", pause, 6'b001111);
    check("exc_cnt_frozen", stall_cycles, 3);
    stall_req = '0;

    // ertn with same-cycle ERA bypass; later CSR writes must not change target
    era_pc = 32'h100; wb_csr_we = 1'b1; wb_csr_waddr = 14'h006; wb_csr_wdata = 32'h200;
    is_ertn = 1'b1;
    tick();
    is_ertn = 1'b0; wb_csr_wdata = 32'h300;
    check("ertn_pc", redirect_pc, 32'h200);
    check("ertn_flag", redirect_ertn, 1);
    tick();
    check("ertn_pc_after", redirect_pc, 32'h200);
    check("ertn_valid_drop", redirect_valid, 0);
    wb_csr_we = 1'b0;

    // Exception with EENTRY bypass and ready low; events mid-wait ignored
    redirect_ready = 1'b0; eentry_va = 32'h1c00_8000;
    wb_csr_we = 1'b1; wb_csr_waddr = 14'h00c; wb_csr_wdata = 32'h2000;
    is_exception = 1'b1;
    tick();
    is_exception = 1'b0; wb_csr_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("wait_valid", redirect_valid, 1);
      check("wait_pc", redirect_pc, 32'h2000);
      check("wait_flush", flush, 6'h3f);
      check("wait_ertn", redirect_ertn, 0);
      is_exception = (i == 1); is_ertn = (i == 1); era_pc = 32'h500;
      redirect_ready = (i == 3);
      tick();
    end
    is_exception = 1'b0; is_ertn = 1'b0;
    check("wait_exit_valid", redirect_valid, 0);
    check("wait_exit_flush", flush, 0);
    check("wait_exit_pc", redirect_pc, 32'h2000);

    // Simultaneous exception and ertn: ERA wins
    era_pc = 32'h440; eentry_va = 32'h880; is_exception = 1'b1; is_ertn = 1'b1;
    tick();
    is_exception = 1'b0; is_ertn = 1'b0;
    check("both_pc", redirect_pc, 32'h440);
    check("both_ertn", redirect_ertn, 1);
    tick();
    check("both_exit", redirect_valid, 0);

    // Back-to-back event in the first IDLE cycle
    eentry_va = 32'h990; is_exception = 1'b1;
    tick();
    is_exception = 1'b0; redirect_ready = 1'b0;
    check("b2b_valid", redirect_valid, 1);
    check("b2b_pc", redirect_pc, 32'h990);
    check("b2b_ertn", redirect_ertn, 0);
    tick();
    check("b2b_held", redirect_valid, 1);

    // Reset while redirecting
    stall_req = 6'b001000;
    rst_n = 1'b0; #1;
    check("rstmid_valid", redirect_valid, 0);
    check("rstmid_pc", redirect_pc, 0);
    check("rstmid_flush", flush, 0);
    check("rstmid_pause", pause, 0);
    tick();
    stall_req = '0; redirect_ready = 1'b1; rst_n = 1'b1;
    tick(); tick();
    check("rel_valid", redirect_valid, 0);
    check("rel_flush", flush, 0);
    check("rel_cnt", stall_cycles, 0);

    // Counter saturation on the CNT_W=4 instance
    stall_req = 6'b001000;
    for (int i = 0; i < 15; i++) tick();
    check("sat15_cnt4", stall_cycles4, 4'hf);
    for (int i = 0; i < 5; i++) tick();
    check("sat20_cnt4", stall_cycles4, 4'hf);
    check("sat20_cnt32", stall_cycles, 20);
    stall_req = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
